// File: rtl/activation_pipe_multi.sv
// activation_pipe_multi: sequences a vector of signed sums through a 3-stage sigmoid/ReLU activation pipeline
// Ports: clk, rst (async, active-high); in_valid/in_ready accept a vector of CHANNELS sums (sum_vec) and biases (bias_vec);
// out_valid/out_ready deliver one activation (out_data) per channel with its index (out_ch) and out_last on the final channel.
// Optional macro ACTFN_RELU_MODE_EN adds input mode (captured with the vector): 1 = clamped ReLU, 0 = sigmoid approximation.
module activation_pipe_multi #(
  parameter int SUM_W     = 62,
  parameter int BIAS_W    = 6,
  parameter int ACT_W     = 16,
  parameter int FRAC_BITS = 8,
  parameter int CHANNELS  = 4,
  localparam int CW       = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*SUM_W-1:0]  sum_vec,
  input  logic [CHANNELS*BIAS_W-1:0] bias_vec,
`ifdef ACTFN_RELU_MODE_EN
  input  logic                       mode,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACT_W-1:0]           out_data,
  output logic [CW-1:0]              out_ch,
  output logic                       out_last
);
  localparam int XW  = SUM_W + 1;
  localparam int OPW = FRAC_BITS + 2;
  localparam int PW  = 2 * OPW;
  localparam logic signed [XW-1:0] TWO = XW'(64'd1 << (FRAC_BITS + 1));
  localparam logic [PW-1:0] ONE = PW'(64'd1 << FRAC_BITS);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t                     state;
  logic [CW-1:0]              idx;
  logic [CHANNELS*SUM_W-1:0]  sum_r;
  logic [CHANNELS*BIAS_W-1:0] bias_r;
  logic                       mode_r;
  logic stall, inject, last_idx;
  logic signed [SUM_W-1:0]  s_sel;
  logic signed [BIAS_W-1:0] b_sel;
  logic signed [XW-1:0]     x;
  logic [1:0]               cls;
  logic [OPW-1:0]           op;
  logic [ACT_W-1:0]         rl;
  logic            v1, last1, m1;
  logic [1:0]      cls1;
  logic [OPW-1:0]  op1;
  logic [CW-1:0]   ch1;
  logic [ACT_W-1:0] rl1;
  logic            v2, last2, m2;
  logic [1:0]      cls2;
  logic [PW-1:0]   sq2;
  logic [CW-1:0]   ch2;
  logic [ACT_W-1:0] rl2;
  logic [PW-1:0]   sh, res;
  logic [ACT_W-1:0] sig;
  // a held output freezes the whole pipe, including the sequencer and acceptance
  assign stall    = out_valid && !out_ready;
  assign in_ready = state == IDLE && !stall;
  assign inject   = state == ISSUE && !stall;
  assign last_idx = idx == CW'(CHANNELS - 1);
  assign s_sel = sum_r[idx*SUM_W +: SUM_W];
  assign b_sel = bias_r[idx*BIAS_W +: BIAS_W];
  assign x     = XW'(s_sel) + XW'(b_sel);
  // cls: 0 -> zero, 1 -> rising square, 2 -> ONE minus square, 3 -> ONE
  assign cls = x < -TWO ? 2'd0 : x[XW-1] ? 2'd1 : x > TWO ? 2'd3 : 2'd2;
  // only meaningful for cls 1/2, where the operand lies in [0, 2*ONE]
  assign op  = x[XW-1] ? OPW'(x + TWO) : OPW'(TWO - x);
  assign rl  = x[XW-1] ? '0 : |(x >> ACT_W) ? '1 : ACT_W'(x);
  assign sh  = sq2 >> (FRAC_BITS + 3);
  assign res = cls2 == 2'd0 ? '0 : cls2 == 2'd1 ? sh : cls2 == 2'd2 ? (sh > ONE ? '0 : ONE - sh) : ONE;
  assign sig = |(res >> ACT_W) ? '1 : ACT_W'(res);
`ifdef ACTFN_RELU_MODE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) mode_r <= 1'b0;
    else if (in_valid && in_ready) mode_r <= mode;
`else
  assign mode_r = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE; idx <= '0; sum_r <= '0; bias_r <= '0;
      v1 <= 1'b0; cls1 <= '0; op1 <= '0; ch1 <= '0; last1 <= 1'b0; rl1 <= '0; m1 <= 1'b0;
      v2 <= 1'b0; cls2 <= '0; sq2 <= '0; ch2 <= '0; last2 <= 1'b0; rl2 <= '0; m2 <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_ch <= '0; out_last <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        state <= ISSUE; idx <= '0; sum_r <= sum_vec; bias_r <= bias_vec;
      end else if (inject) begin
        idx <= last_idx ? '0 : idx + 1'b1;
        if (last_idx) state <= IDLE;
      end
      if (!stall) begin
        v1 <= inject; cls1 <= cls; op1 <= op; ch1 <= idx; last1 <= last_idx; rl1 <= rl; m1 <= mode_r;
        v2 <= v1; cls2 <= cls1; sq2 <= PW'(op1) * PW'(op1); ch2 <= ch1; last2 <= last1; rl2 <= rl1; m2 <= m1;
        out_valid <= v2; out_data <= m2 ? rl2 : sig; out_ch <= ch2; out_last <= last2;
      end
    end
endmodule

// File: tb/tb_activation_pipe_multi.sv
// tb_activation_pipe_multi: randomized and directed self-checking bench for activation_pipe_multi
module tb_activation_pipe_multi;
  localparam int SUM_W = 62, BIAS_W = 6, ACT_W = 16, FRAC_BITS = 8, CHANNELS = 4, CW = 2;
  typedef struct {
    logic [CHANNELS*SUM_W-1:0]  s;
    logic [CHANNELS*BIAS_W-1:0] b;
    bit m;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_last;
  logic [CHANNELS*SUM_W-1:0]  sum_vec = '0;
  logic [CHANNELS*BIAS_W-1:0] bias_vec = '0;
  logic [ACT_W-1:0] out_data;
  logic [CW-1:0]    out_ch;
`ifdef ACTFN_RELU_MODE_EN
  logic mode = 1'b0;
`endif
  int vectors = 0, miscompares = 0;
  activation_pipe_multi dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum_vec(sum_vec), .bias_vec(bias_vec),
`ifdef ACTFN_RELU_MODE_EN
    .mode(mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last));
  always #5 clk = ~clk;
  // reference: the activation rules evaluated on plain integers
  function automatic longint ref_act(input longint x, input bit m);
    longint one = longint'(1) << FRAC_BITS;
    longint amax = (longint'(1) << ACT_W) - 1;
    longint r;
    if (m) r = x;
    else if (x < -2 * one) r = 0;
    else if (x < 0) r = ((x + 2 * one) * (x + 2 * one)) / (longint'(1) << (FRAC_BITS + 3));
    else if (x <= 2 * one) r = one - ((2 * one - x) * (2 * one - x)) / (longint'(1) << (FRAC_BITS + 3));
    else r = one;
    return r < 0 ? 0 : r > amax ? amax : r;
  endfunction
  function automatic int chan_exp(input vec_t v, input int k);
    logic signed [SUM_W-1:0]  s = v.s[k*SUM_W +: SUM_W];
    logic signed [BIAS_W-1:0] b = v.b[k*BIAS_W +: BIAS_W];
    return int'(ref_act(longint'(s) + longint'(b), v.m));
  endfunction
  function automatic vec_t mk(input longint s[CHANNELS], input longint b[CHANNELS], input bit m);
    vec_t v;
    for (int k = 0; k < CHANNELS; k++) begin
      v.s[k*SUM_W +: SUM_W] = SUM_W'(s[k]);
      v.b[k*BIAS_W +: BIAS_W] = BIAS_W'(b[k]);
    end
    v.m = m;
    return v;
  endfunction
  function automatic vec_t rnd_vec();
    vec_t v;
    for (int k = 0; k < CHANNELS; k++) begin
      v.s[k*SUM_W +: SUM_W] = $urandom_range(0, 3) == 0 ? SUM_W'({$urandom, $urandom})
                                                         : SUM_W'(longint'($urandom_range(0, 2400)) - 1200);
      v.b[k*BIAS_W +: BIAS_W] = BIAS_W'($urandom);
    end
`ifdef ACTFN_RELU_MODE_EN
    v.m = 1'($urandom_range(0, 1));
`else
    v.m = 1'b0;
`endif
    return v;
  endfunction
  task automatic set_in(input vec_t v);
    in_valid = 1'b1; sum_vec = v.s; bias_vec = v.b;
`ifdef ACTFN_RELU_MODE_EN
    mode = v.m;
`endif
  endtask
  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_async out_valid got %0b exp 0", out_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready got %0b exp 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid got %0b exp 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset out_data got %0d exp 0", out_data); end
    vectors++; if ({out_ch, out_last} !== '0) begin miscompares++; $display("FAIL reset out_ch/out_last got %0d/%0b exp 0/0", out_ch, out_last); end
  endtask
  // exact-latency check for one vector with the output always ready
  task automatic test_latency_vec(input string name, input vec_t v);
    bit ev;
    @(negedge clk);
    out_ready = 1'b1; set_in(v);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s accept in_ready got %0b exp 1", name, in_ready); end
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      ev = c >= 3 && c < 3 + CHANNELS;
      vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL %s out_valid cycle %0d got %0b exp %0b", name, c, out_valid, ev); end
      if (ev) begin
        vectors++;
        if ({out_data, out_ch, out_last} !== {ACT_W'(chan_exp(v, c - 3)), CW'(c - 3), c - 3 == CHANNELS - 1}) begin
          miscompares++;
          $display("FAIL %s ch%0d got data=%0d ch=%0d last=%0b exp data=%0d ch=%0d last=%0b", name, c - 3,
                   out_data, out_ch, out_last, chan_exp(v, c - 3), c - 3, c - 3 == CHANNELS - 1);
        end
      end
      if (c < CHANNELS) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL %s in_ready during issue cycle %0d got %0b exp 0", name, c, in_ready); end
      end
    end
  endtask
  task automatic test_stall();
    vec_t v = mk('{-512, -256, 0, 256}, '{0, 0, 0, 0}, 1'b0);
    int got = 0, held = 0;
    @(negedge clk);
    out_ready = 1'b1; set_in(v);
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c < CHANNELS) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall in_ready cycle %0d got %0b exp 0", c, in_ready); end
      end
      if (out_valid && got == 1 && held < 5) begin
        out_ready = 1'b0; held++;
        vectors++;
        if ({out_data, out_ch} !== {ACT_W'(chan_exp(v, 1)), CW'(1)}) begin
          miscompares++; $display("FAIL stall hold got data=%0d ch=%0d exp data=%0d ch=1", out_data, out_ch, chan_exp(v, 1));
        end
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          vectors++;
          if (got >= CHANNELS) begin
            miscompares++; $display("FAIL stall duplicate got ch=%0d exp no output", out_ch);
          end else if ({out_data, out_ch, out_last} !== {ACT_W'(chan_exp(v, got)), CW'(got), got == CHANNELS - 1}) begin
            miscompares++; $display("FAIL stall ch%0d got data=%0d ch=%0d last=%0b exp data=%0d", got, out_data, out_ch, out_last, chan_exp(v, got));
          end
          got++;
        end
      end
    end
    vectors++; if (got != CHANNELS || held != 5) begin miscompares++; $display("FAIL stall count got %0d/%0d exp %0d/5", got, held, CHANNELS); end
  endtask
  task automatic test_back_to_back();
    vec_t pend[$];
    int ed[$], ec[$];
    int last_acc = -1, d, c;
    for (int i = 0; i < 3; i++) pend.push_back(rnd_vec());
    for (int cyc = 0; cyc < 100 && (pend.size() > 0 || ed.size() > 0); cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (pend.size() > 0) set_in(pend[0]); else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        vectors++;
        if (ed.size() == 0) begin miscompares++; $display("FAIL b2b unexpected output ch=%0d", out_ch); end
        else begin
          d = ed.pop_front(); c = ec.pop_front();
          if ({out_data, out_ch, out_last} !== {ACT_W'(d), CW'(c), c == CHANNELS - 1}) begin
            miscompares++; $display("FAIL b2b got data=%0d ch=%0d last=%0b exp data=%0d ch=%0d", out_data, out_ch, out_last, d, c);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (last_acc >= 0) begin
          vectors++; if (cyc - last_acc != CHANNELS + 1) begin miscompares++; $display("FAIL b2b accept gap got %0d exp %0d", cyc - last_acc, CHANNELS + 1); end
        end
        last_acc = cyc;
        for (int k = 0; k < CHANNELS; k++) begin ed.push_back(chan_exp(pend[0], k)); ec.push_back(k); end
        void'(pend.pop_front());
      end
    end
    in_valid = 1'b0;
    vectors++; if (pend.size() + ed.size() != 0) begin miscompares++; $display("FAIL b2b timeout pending=%0d outstanding=%0d exp 0", pend.size(), ed.size()); end
  endtask
  task automatic test_reset_mid();
    vec_t v = mk('{-512, -256, 0, 256}, '{0, 0, 0, 0}, 1'b0);
    @(negedge clk);
    out_ready = 1'b1; set_in(v);
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset out_valid got %0b exp 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset in_ready got %0b exp 1", in_ready); end
    vectors++; if ({out_data, out_ch, out_last} !== '0) begin miscompares++; $display("FAIL midreset outputs got %0d/%0d/%0b exp 0", out_data, out_ch, out_last); end
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset stale output cycle %0d got ch=%0d exp none", c, out_ch); end
    end
  endtask
  task automatic test_random(input int nvec);
    vec_t pend[$];
    int ed[$], ec[$];
    int d, c;
    for (int i = 0; i < nvec; i++) pend.push_back(rnd_vec());
    for (int cyc = 0; cyc < 3000 && (pend.size() > 0 || ed.size() > 0); cyc++) begin
      @(negedge clk);
      out_ready = $urandom_range(0, 99) < 70;
      if (pend.size() > 0 && $urandom_range(0, 3) != 0) set_in(pend[0]); else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (ed.size() == 0) begin miscompares++; $display("FAIL random unexpected output ch=%0d", out_ch); end
        else begin
          d = ed.pop_front(); c = ec.pop_front();
          if ({out_data, out_ch, out_last} !== {ACT_W'(d), CW'(c), c == CHANNELS - 1}) begin
            miscompares++; $display("FAIL random got data=%0d ch=%0d last=%0b exp data=%0d ch=%0d", out_data, out_ch, out_last, d, c);
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < CHANNELS; k++) begin ed.push_back(chan_exp(pend[0], k)); ec.push_back(k); end
        void'(pend.pop_front());
      end
    end
    in_valid = 1'b0;
    vectors++; if (pend.size() + ed.size() != 0) begin miscompares++; $display("FAIL random timeout pending=%0d outstanding=%0d exp 0", pend.size(), ed.size()); end
  endtask
  initial begin
    test_reset();
    test_latency_vec("sigmoid_ramp", mk('{-512, -256, 0, 256}, '{0, 0, 0, 0}, 1'b0));
    test_latency_vec("sigmoid_edges", mk('{512, 1000, -1000, 255}, '{0, 0, 0, 1}, 1'b0));
`ifdef ACTFN_RELU_MODE_EN
    test_latency_vec("relu", mk('{-5, 0, 300, 70000}, '{0, 0, 0, 0}, 1'b1));
`endif
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
